// File: rtl/spring_force_accum.sv
// rtl/spring_force_accum.sv - pipelined Hooke-plus-damper spring force engine with per-node force accumulation
// Optional feature macro: SPRING_SAT_EN (saturate forces and accumulators instead of truncating/wrapping).
module spring_force_accum #(
    parameter int NUM_SPRINGS   = 2,
    parameter int NUM_NODES     = 3,
    parameter int CONSTANT_SIZE = 4,
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 8,
    parameter int FORCE_SIZE    = 12,
    localparam int NW = $clog2(NUM_NODES) + 1,
    localparam int IW = $clog2(NUM_SPRINGS) + 1
) (
    input  logic                                                clk_in,
    input  logic                                                rst_in,
    input  logic                                                input_valid,
    output logic                                                ready_out,
    input  logic [CONSTANT_SIZE-1:0]                            k,
    input  logic [CONSTANT_SIZE-1:0]                            b,
    input  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]   nodes,
    input  logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]   velocities,
    input  logic [1:0][NUM_SPRINGS-1:0][NW-1:0]                 springs,
    input  logic signed [1:0][NUM_SPRINGS-1:0][POSITION_SIZE-1:0] equilibriums,
    output logic signed [FORCE_SIZE-1:0]                        spring_force_x,
    output logic signed [FORCE_SIZE-1:0]                        spring_force_y,
    output logic [IW-1:0]                                       spring_index,
    output logic                                                spring_force_valid,
    output logic signed [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0]      node_forces,
    output logic                                                output_valid
);

    localparam int DW = POSITION_SIZE + 1;
    localparam int EW = POSITION_SIZE + 2;
    localparam int VW = VELOCITY_SIZE + 1;
    // k*e and b*dv each need CONSTANT_SIZE+1+operand bits; one more for the sum.
    localparam int PW = CONSTANT_SIZE + 2 + ((EW > VW) ? EW : VW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] LAST_SPRING = IW'(NUM_SPRINGS - 1);

`ifdef SPRING_SAT_EN
    localparam logic signed [FORCE_SIZE-1:0] F_MAX = {1'b0, {(FORCE_SIZE-1){1'b1}}};
    localparam logic signed [FORCE_SIZE-1:0] F_MIN = {1'b1, {(FORCE_SIZE-1){1'b0}}};
    localparam logic signed [PW-1:0] F_MAX_W = {{(PW-FORCE_SIZE+1){1'b0}}, {(FORCE_SIZE-1){1'b1}}};
    localparam logic signed [PW-1:0] F_MIN_W = {{(PW-FORCE_SIZE+1){1'b1}}, {(FORCE_SIZE-1){1'b0}}};
`endif

    // Full-precision force reduced to the output width.
    function automatic logic signed [FORCE_SIZE-1:0] reduce_force(input logic signed [PW-1:0] x);
`ifdef SPRING_SAT_EN
        if (x > F_MAX_W) return F_MAX;
        else if (x < F_MIN_W) return F_MIN;
        else return FORCE_SIZE'(x);
`else
        return FORCE_SIZE'(x);
`endif
    endfunction

    // Opposite-direction contribution for endpoint b.
    function automatic logic signed [FORCE_SIZE-1:0] negate_force(input logic signed [FORCE_SIZE-1:0] x);
`ifdef SPRING_SAT_EN
        if (x == F_MIN) return F_MAX;
        else return -x;
`else
        return -x;
`endif
    endfunction

    // Accumulator add: clamps on overflow when saturating, wraps otherwise.
    function automatic logic signed [FORCE_SIZE-1:0] acc_add(input logic signed [FORCE_SIZE-1:0] x,
                                                             input logic signed [FORCE_SIZE-1:0] y);
`ifdef SPRING_SAT_EN
        logic signed [FORCE_SIZE:0] s;
        s = (FORCE_SIZE+1)'(x) + (FORCE_SIZE+1)'(y);
        if (s[FORCE_SIZE] != s[FORCE_SIZE-1]) return s[FORCE_SIZE] ? F_MIN : F_MAX;
        else return s[FORCE_SIZE-1:0];
`else
        return x + y;
`endif
    endfunction

    logic [1:0]    state_q;
    logic [IW-1:0] cnt_q;
    logic          issuing_q;
    logic          out_valid_q;
    logic          accept;

    logic [CONSTANT_SIZE-1:0]                            k_q, b_q;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]        nodes_q;
    logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]        vel_q;
    logic [1:0][NUM_SPRINGS-1:0][NW-1:0]                 springs_q;
    logic [1:0][NUM_SPRINGS-1:0][POSITION_SIZE-1:0]      eq_q;

    logic [NW-1:0]                     sel_a, sel_b;
    logic signed [POSITION_SIZE-1:0]   pa, pb, eqv;
    logic signed [VELOCITY_SIZE-1:0]   va, vb;
    logic signed [DW-1:0]              d;
    logic signed [EW-1:0]              e_d [2];
    logic signed [VW-1:0]              dv_d [2];

    logic                              s1_valid_q, s1_last_q;
    logic [NW-1:0]                     s1_a_q, s1_b_q;
    logic [IW-1:0]                     s1_idx_q;
    logic signed [EW-1:0]              e_q [2];
    logic signed [VW-1:0]              dv_q [2];

    logic signed [PW-1:0]              kx, bx, ex, vx, full;
    logic signed [FORCE_SIZE-1:0]      f_d [2];
    logic signed [FORCE_SIZE-1:0]      fneg;
    logic signed [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0] acc_d, acc_q;

    logic                              sfv_q, s2_last_q;
    logic signed [FORCE_SIZE-1:0]      fx_q, fy_q;
    logic [IW-1:0]                     idx_q;

    assign ready_out          = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept             = ready_out && input_valid;
    assign output_valid       = out_valid_q;
    assign spring_force_valid = sfv_q;
    assign spring_force_x     = fx_q;
    assign spring_force_y     = fy_q;
    assign spring_index       = idx_q;
    assign node_forces        = acc_q;

    // Pass sequencing: accept, issue one spring per cycle, then wait for the pipeline to drain.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            issuing_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (input_valid) begin
                        state_q   <= S_CALC;
                        cnt_q     <= '0;
                        issuing_q <= 1'b1;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (issuing_q) begin
                        cnt_q <= cnt_q + IW'(1);
                        if (cnt_q == LAST_SPRING) issuing_q <= 1'b0;
                    end
                    if (s2_last_q) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Request snapshot; the live inputs are free to change once accepted.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            k_q       <= '0;
            b_q       <= '0;
            nodes_q   <= '0;
            vel_q     <= '0;
            springs_q <= '0;
            eq_q      <= '0;
        end else if (accept) begin
            k_q       <= k;
            b_q       <= b;
            nodes_q   <= nodes;
            vel_q     <= velocities;
            springs_q <= springs;
            eq_q      <= equilibriums;
        end
    end

    // Stage 1 operands: endpoint differences and extension; out-of-range endpoints read as zero.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        pa = '0; pb = '0; va = '0; vb = '0; eqv = '0; d = '0;
        for (int s = 0; s < NUM_SPRINGS; s++) begin
            if (cnt_q == IW'(s)) begin
                sel_a = springs_q[0][s];
                sel_b = springs_q[1][s];
            end
        end
        for (int ax = 0; ax < 2; ax++) begin
            pa = '0; pb = '0; va = '0; vb = '0; eqv = '0;
            for (int n = 0; n < NUM_NODES; n++) begin
                if (sel_a == NW'(n)) begin
                    pa = nodes_q[ax][n];
                    va = vel_q[ax][n];
                end
                if (sel_b == NW'(n)) begin
                    pb = nodes_q[ax][n];
                    vb = vel_q[ax][n];
                end
            end
            for (int s = 0; s < NUM_SPRINGS; s++) begin
                if (cnt_q == IW'(s)) eqv = eq_q[ax][s];
            end
            d        = DW'(pb) - DW'(pa);
            e_d[ax]  = EW'(d) - EW'(eqv);
            dv_d[ax] = VW'(vb) - VW'(va);
        end
    end

    // Stage 1 register: one spring issued per cycle while the counter walks the list.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_idx_q   <= '0;
            for (int ax = 0; ax < 2; ax++) begin
                e_q[ax]  <= '0;
                dv_q[ax] <= '0;
            end
        end else begin
            s1_valid_q <= (state_q == S_CALC) && issuing_q;
            if (issuing_q) begin
                s1_last_q <= (cnt_q == LAST_SPRING);
                s1_a_q    <= sel_a;
                s1_b_q    <= sel_b;
                s1_idx_q  <= cnt_q;
                for (int ax = 0; ax < 2; ax++) begin
                    e_q[ax]  <= e_d[ax];
                    dv_q[ax] <= dv_d[ax];
                end
            end
        end
    end

    // Stage 2 math: F = k*e + b*dv, then equal-and-opposite accumulation; a self-spring leaves its node unchanged.
    always_comb begin
        kx    = PW'($signed({1'b0, k_q}));
        bx    = PW'($signed({1'b0, b_q}));
        ex    = '0;
        vx    = '0;
        full  = '0;
        fneg  = '0;
        acc_d = acc_q;
        for (int ax = 0; ax < 2; ax++) begin
            ex      = PW'(e_q[ax]);
            vx      = PW'(dv_q[ax]);
            full    = kx * ex + bx * vx;
            f_d[ax] = reduce_force(full);
            fneg    = negate_force(f_d[ax]);
            if (s1_a_q != s1_b_q) begin
                for (int n = 0; n < NUM_NODES; n++) begin
                    if (s1_a_q == NW'(n)) acc_d[ax][n] = acc_add(acc_q[ax][n], f_d[ax]);
                    if (s1_b_q == NW'(n)) acc_d[ax][n] = acc_add(acc_q[ax][n], fneg);
                end
            end
        end
    end

    // Stage 2 register: force stream, done tracking and accumulators (cleared on each new request).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sfv_q     <= 1'b0;
            s2_last_q <= 1'b0;
            fx_q      <= '0;
            fy_q      <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
        end else begin
            sfv_q     <= s1_valid_q;
            s2_last_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                fx_q  <= f_d[0];
                fy_q  <= f_d[1];
                idx_q <= s1_idx_q;
            end
            if (accept) acc_q <= '0;
            else if (s1_valid_q) acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_spring_force_accum.sv
// tb/tb_spring_force_accum.sv - scoreboard bench for spring_force_accum (default and small-force instances)
`timescale 1ns/1ps
module tb_spring_force_accum;

    localparam int NS  = 2;
    localparam int NN  = 3;
    localparam int FS  = 12;
    localparam int NWB = $clog2(NN) + 1;
    localparam int IWB = $clog2(NS) + 1;
    localparam int LAT = NS + 2;

`ifdef SPRING_SAT_EN
    localparam int SAT_FX = 31;
`else
    localparam int SAT_FX = 28;
`endif

    logic clk, rst_n;

    logic                        iv, rdy, sfv, ov;
    logic [3:0]                  k, bb;
    logic [1:0][NN-1:0][7:0]     nodes, vels;
    logic [1:0][NS-1:0][NWB-1:0] springs;
    logic [1:0][NS-1:0][7:0]     eqs;
    logic signed [FS-1:0]        fx, fy;
    logic [IWB-1:0]              sidx;
    logic [1:0][NN-1:0][FS-1:0]  nf;

    logic                        iv2, rdy2, sfv2, ov2;
    logic [3:0]                  k2, b2;
    logic [1:0][1:0][7:0]        nodes2, vels2;
    logic [1:0][0:0][1:0]        springs2;
    logic [1:0][0:0][7:0]        eqs2;
    logic signed [5:0]           fx2, fy2;
    logic [0:0]                  sidx2;
    logic [1:0][1:0][5:0]        nf2;

    spring_force_accum dut (
        .clk_in(clk), .rst_in(rst_n), .input_valid(iv), .ready_out(rdy),
        .k(k), .b(bb), .nodes(nodes), .velocities(vels), .springs(springs), .equilibriums(eqs),
        .spring_force_x(fx), .spring_force_y(fy), .spring_index(sidx), .spring_force_valid(sfv),
        .node_forces(nf), .output_valid(ov)
    );

    spring_force_accum #(.NUM_SPRINGS(1), .NUM_NODES(2), .FORCE_SIZE(6)) dut_small (
        .clk_in(clk), .rst_in(rst_n), .input_valid(iv2), .ready_out(rdy2),
        .k(k2), .b(b2), .nodes(nodes2), .velocities(vels2), .springs(springs2), .equilibriums(eqs2),
        .spring_force_x(fx2), .spring_force_y(fy2), .spring_index(sidx2), .spring_force_valid(sfv2),
        .node_forces(nf2), .output_valid(ov2)
    );

    typedef struct {
        logic [IWB-1:0]       idx;
        logic signed [FS-1:0] fx;
        logic signed [FS-1:0] fy;
    } exp_t;

    exp_t                 sb[$];
    exp_t                 mon_e;
    logic signed [FS-1:0] exp_nf [2][NN];
    int                   checks, errors, ov_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor for the default instance's force stream.
    always @(negedge clk) begin
        if (rst_n && sfv) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected got idx=%0d fx=%0d fy=%0d expected no strobe", sidx, fx, fy);
            end else begin
                mon_e = sb.pop_front();
                if (sidx !== mon_e.idx || fx !== mon_e.fx || fy !== mon_e.fy) begin
                    errors++;
                    $display("FAIL strobe got idx=%0d fx=%0d fy=%0d expected idx=%0d fx=%0d fy=%0d",
                             sidx, fx, fy, mon_e.idx, mon_e.fx, mon_e.fy);
                end
            end
        end
        if (rst_n && ov) ov_count++;
    end

    task automatic push(input int idx, input int efx, input int efy);
        exp_t e;
        e.idx = IWB'(idx);
        e.fx  = FS'(efx);
        e.fy  = FS'(efy);
        sb.push_back(e);
    endtask

    task automatic set_exp(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
        exp_nf[0][0] = FS'(x0); exp_nf[1][0] = FS'(y0);
        exp_nf[0][1] = FS'(x1); exp_nf[1][1] = FS'(y1);
        exp_nf[0][2] = FS'(x2); exp_nf[1][2] = FS'(y2);
    endtask

    task automatic drive_nominal();
        k = 4'd2; bb = 4'd1;
        nodes[0][0] = 8'(3);  nodes[1][0] = 8'(4);
        nodes[0][1] = 8'(6);  nodes[1][1] = 8'(8);
        nodes[0][2] = 8'(12); nodes[1][2] = 8'(-2);
        vels[0][0]  = 8'(1);  vels[1][0]  = 8'(2);
        vels[0][1]  = 8'(-2); vels[1][1]  = 8'(-3);
        vels[0][2]  = 8'(5);  vels[1][2]  = 8'(8);
        springs[0][0] = 3'd0; springs[1][0] = 3'd1;
        springs[0][1] = 3'd1; springs[1][1] = 3'd2;
        eqs = '0;
    endtask

    task automatic accept();
        @(negedge clk);
        iv = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
    endtask

    task automatic wait_ov(output int lat);
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ov) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iv = 1'b0; iv2 = 1'b0;
        drive_nominal();
        k2 = '0; b2 = '0; nodes2 = '0; vels2 = '0; springs2 = '0; eqs2 = '0;
        repeat (2) @(negedge clk);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", rdy); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_output_valid got %b expected 0", ov); end
        checks++; if (sfv !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b expected 0", sfv); end
        checks++; if (fx !== '0 || fy !== '0) begin errors++; $display("FAIL reset_force got %0d,%0d expected 0,0", fx, fy); end
        checks++; if (sidx !== '0) begin errors++; $display("FAIL reset_index got %0d expected 0", sidx); end
        checks++; if (nf !== '0) begin errors++; $display("FAIL reset_node_forces got %h expected 0", nf); end
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_ready_small got %b expected 1", rdy2); end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        int lat;
        drive_nominal();
        push(0, 3, 3);
        push(1, 19, -9);
        set_exp(3, 3, 16, -12, -19, 9);
        accept();
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL nominal_ready_after_accept got %b expected 0", rdy); end
        wait_ov(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL nominal_latency got %0d expected %0d", lat, LAT); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL nominal_ready_done got %b expected 1", rdy); end
        for (int ax = 0; ax < 2; ax++) for (int n = 0; n < NN; n++) begin
            checks++;
            if (nf[ax][n] !== exp_nf[ax][n]) begin
                errors++;
                $display("FAIL nominal_node_force[%0d][%0d] got %0d expected %0d", ax, n, $signed(nf[ax][n]), exp_nf[ax][n]);
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL nominal_strobes_left got %0d expected 0", sb.size()); end
        @(negedge clk);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL nominal_ov_pulse got %b expected 0", ov); end
        checks++; if (nf[0][1] !== exp_nf[0][1]) begin errors++; $display("FAIL nominal_hold got %0d expected %0d", $signed(nf[0][1]), exp_nf[0][1]); end
    endtask

    task automatic test_saturation();
        int  lat;
        bit  seen;
        logic signed [5:0] gfx, gfy;
        k2 = 4'd15; b2 = 4'd0;
        nodes2 = '0; nodes2[0][1] = 8'(100);
        vels2 = '0; eqs2 = '0;
        springs2[0][0] = 2'd0; springs2[1][0] = 2'd1;
        lat = -1; seen = 1'b0; gfx = '0; gfy = '0;
        @(negedge clk);
        iv2 = 1'b1;
        @(posedge clk);
        #1 iv2 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sfv2) begin seen = 1'b1; gfx = fx2; gfy = fy2; end
            if (ov2) begin lat = c; break; end
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL sat_latency got %0d expected 3", lat); end
        checks++; if (!seen) begin errors++; $display("FAIL sat_strobe got none expected one"); end
        checks++; if (gfx !== 6'(SAT_FX) || gfy !== 6'(0)) begin errors++; $display("FAIL sat_force got %0d,%0d expected %0d,0", gfx, gfy, SAT_FX); end
        checks++; if (nf2[0][0] !== 6'(SAT_FX) || nf2[1][0] !== 6'(0)) begin errors++; $display("FAIL sat_node0 got %0d,%0d expected %0d,0", $signed(nf2[0][0]), $signed(nf2[1][0]), SAT_FX); end
        checks++; if (nf2[0][1] !== 6'(-SAT_FX) || nf2[1][1] !== 6'(0)) begin errors++; $display("FAIL sat_node1 got %0d,%0d expected %0d,0", $signed(nf2[0][1]), $signed(nf2[1][1]), -SAT_FX); end
    endtask

    task automatic test_busy();
        int lat, ov_before;
        drive_nominal();
        push(0, 3, 3);
        push(1, 19, -9);
        set_exp(3, 3, 16, -12, -19, 9);
        ov_before = ov_count;
        lat = -1;
        accept();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            iv = (c < 3);
            if (ov && lat < 0) lat = c;
        end
        iv = 1'b0;
        checks++; if (lat != LAT) begin errors++; $display("FAIL busy_latency got %0d expected %0d", lat, LAT); end
        checks++; if (ov_count - ov_before != 1) begin errors++; $display("FAIL busy_ov_count got %0d expected 1", ov_count - ov_before); end
        for (int ax = 0; ax < 2; ax++) for (int n = 0; n < NN; n++) begin
            checks++;
            if (nf[ax][n] !== exp_nf[ax][n]) begin
                errors++;
                $display("FAIL busy_node_force[%0d][%0d] got %0d expected %0d", ax, n, $signed(nf[ax][n]), exp_nf[ax][n]);
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL busy_strobes_left got %0d expected 0", sb.size()); end
    endtask

    task automatic test_degenerate();
        int lat;
        drive_nominal();
        springs[0][0] = 3'd0; springs[1][0] = 3'd0;
        springs[0][1] = 3'd1; springs[1][1] = 3'd3;
        eqs[0][0] = 8'(5);
        // self-spring: e=(-5,0) -> (-10,0); node1->node3 with node3 read as zero: e=(-6,-8), dv=(2,3)
        push(0, -10, 0);
        push(1, -10, -13);
        set_exp(0, 0, -10, -13, 0, 0);
        accept();
        wait_ov(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL degen_latency got %0d expected %0d", lat, LAT); end
        for (int ax = 0; ax < 2; ax++) for (int n = 0; n < NN; n++) begin
            checks++;
            if (nf[ax][n] !== exp_nf[ax][n]) begin
                errors++;
                $display("FAIL degen_node_force[%0d][%0d] got %0d expected %0d", ax, n, $signed(nf[ax][n]), exp_nf[ax][n]);
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL degen_strobes_left got %0d expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid_pass();
        int lat, ov_before;
        drive_nominal();
        accept();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b expected 1", rdy); end
        checks++; if (ov !== 1'b0 || sfv !== 1'b0) begin errors++; $display("FAIL midrst_valids got ov=%b sfv=%b expected 0,0", ov, sfv); end
        checks++; if (fx !== '0 || fy !== '0 || sidx !== '0) begin errors++; $display("FAIL midrst_stream got %0d,%0d,%0d expected 0,0,0", fx, fy, sidx); end
        checks++; if (nf !== '0) begin errors++; $display("FAIL midrst_node_forces got %h expected 0", nf); end
        @(negedge clk);
        rst_n = 1'b1;
        ov_before = ov_count;
        repeat (8) @(negedge clk);
        checks++; if (ov_count != ov_before) begin errors++; $display("FAIL midrst_spurious_ov got %0d expected 0", ov_count - ov_before); end
        push(0, 3, 3);
        push(1, 19, -9);
        set_exp(3, 3, 16, -12, -19, 9);
        accept();
        wait_ov(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL midrst_latency got %0d expected %0d", lat, LAT); end
        for (int ax = 0; ax < 2; ax++) for (int n = 0; n < NN; n++) begin
            checks++;
            if (nf[ax][n] !== exp_nf[ax][n]) begin
                errors++;
                $display("FAIL midrst_node_force[%0d][%0d] got %0d expected %0d", ax, n, $signed(nf[ax][n]), exp_nf[ax][n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, lat2;
        drive_nominal();
        for (int p = 0; p < 2; p++) begin
            push(0, 3, 3);
            push(1, 19, -9);
        end
        set_exp(3, 3, 16, -12, -19, 9);
        @(negedge clk);
        iv = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ov) begin lat = c; break; end
        end
        checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_latency1 got %0d expected %0d", lat, LAT); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_done got %b expected 1", rdy); end
        for (int ax = 0; ax < 2; ax++) for (int n = 0; n < NN; n++) begin
            checks++;
            if (nf[ax][n] !== exp_nf[ax][n]) begin
                errors++;
                $display("FAIL b2b_first_node_force[%0d][%0d] got %0d expected %0d", ax, n, $signed(nf[ax][n]), exp_nf[ax][n]);
            end
        end
        @(negedge clk);
        iv = 1'b0;
        checks++; if (rdy !== 1'b0 || ov !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got rdy=%b ov=%b expected 0,0", rdy, ov); end
        checks++; if (nf !== '0) begin errors++; $display("FAIL b2b_cleared got %h expected 0", nf); end
        lat2 = -1;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (ov) begin lat2 = c; break; end
        end
        checks++; if (lat2 != LAT) begin errors++; $display("FAIL b2b_latency2 got %0d expected %0d", lat2, LAT); end
        for (int ax = 0; ax < 2; ax++) for (int n = 0; n < NN; n++) begin
            checks++;
            if (nf[ax][n] !== exp_nf[ax][n]) begin
                errors++;
                $display("FAIL b2b_second_node_force[%0d][%0d] got %0d expected %0d", ax, n, $signed(nf[ax][n]), exp_nf[ax][n]);
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_strobes_left got %0d expected 0", sb.size()); end
    endtask

    initial begin
        checks = 0; errors = 0; ov_count = 0;
        test_reset();
        test_nominal();
        test_saturation();
        test_busy();
        test_degenerate();
        test_reset_mid_pass();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
